// File: rtl/axis_pkt_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel channels side by side.
// Instantiated once per side: LANES=S_COUNT for the sources, LANES=1 for the merged output.
interface axis_pkt_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [ID_WIDTH-1:0]         tid;

  modport master (output tdata, output tvalid, output tlast, output tid, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tid, output tready);
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter: merges S_COUNT AXI-Stream sources onto one
// master; a grant is held from a packet's first beat until its tlast beat is accepted.
module axis_pkt_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  axis_pkt_arbiter_if.slave  s_axis,
  axis_pkt_arbiter_if.master m_axis,
  output logic [S_COUNT-1:0] grant,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q;
  logic [ID_WIDTH-1:0] grant_idx_q;
  logic [ID_WIDTH-1:0] last_idx_q;
  logic [S_COUNT-1:0]  grant_q;

  logic [ID_WIDTH-1:0] winner_d;
  logic                any_req_d;
  logic                xfer_last;
  int                  scan_idx;

  // First requester after the last-served port; the served port ends up lowest priority.
  always_comb begin
    winner_d  = '0;
    any_req_d = 1'b0;
    scan_idx  = 0;
    for (int i = 1; i <= S_COUNT; i++) begin
      scan_idx = (int'(last_idx_q) + i) % S_COUNT;
      if (!any_req_d && s_axis.tvalid[scan_idx]) begin
        any_req_d = 1'b1;
        winner_d  = ID_WIDTH'(scan_idx);
      end
    end
  end

  assign xfer_last = (state_q == BUSY) && s_axis.tvalid[grant_idx_q]
                     && m_axis.tready[0] && s_axis.tlast[grant_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= ID_WIDTH'(S_COUNT - 1);
      grant_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q     <= BUSY;
            grant_idx_q <= winner_d;
            last_idx_q  <= winner_d;
            grant_q     <= S_COUNT'(1) << winner_d;
          end
        end
        BUSY: begin
          if (xfer_last) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == BUSY);
  assign grant = grant_q;

  // Pass-through data path while granted; everything forced to zero in IDLE.
  assign m_axis.tvalid = busy & s_axis.tvalid[grant_idx_q];
  assign m_axis.tlast  = busy & s_axis.tlast[grant_idx_q];
  assign m_axis.tdata  = busy ? s_axis.tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_axis.tid    = busy ? grant_idx_q : '0;

  generate
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_ready
      assign s_axis.tready[gi] = busy && (grant_idx_q == ID_WIDTH'(gi)) && m_axis.tready[0];
    end
  endgenerate

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: a 2-port and a 4-port instance driven from
// per-port beat lists, with per-cycle observations compared against hand-computed tables.
module tb_axis_pkt_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_pkt_arbiter_if #(.LANES(2), .DATA_WIDTH(32), .ID_WIDTH(1)) s2 ();
  axis_pkt_arbiter_if #(.LANES(1), .DATA_WIDTH(32), .ID_WIDTH(1)) m2 ();
  axis_pkt_arbiter_if #(.LANES(4), .DATA_WIDTH(32), .ID_WIDTH(2)) s4 ();
  axis_pkt_arbiter_if #(.LANES(1), .DATA_WIDTH(32), .ID_WIDTH(2)) m4 ();

  logic [1:0] grant2;
  logic       busy2;
  logic [3:0] grant4;
  logic       busy4;

  axis_pkt_arbiter #(.S_COUNT(2), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .s_axis(s2.slave), .m_axis(m2.master), .grant(grant2), .busy(busy2)
  );
  axis_pkt_arbiter #(.S_COUNT(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .s_axis(s4.slave), .m_axis(m4.master), .grant(grant4), .busy(busy4)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] src_d [4][8];
  logic        src_l [4][8];
  int          src_n [4];
  int          src_start [4];
  bit          mready_sched [32];
  bit          rst_sched [32];

  logic        obs_fire  [32];
  logic [31:0] obs_md    [32];
  logic        obs_ml    [32];
  logic        obs_mv    [32];
  int          obs_tid   [32];
  logic [3:0]  obs_grant [32];
  logic        obs_busy  [32];
  logic [3:0]  obs_sready[32];

  task automatic clear_stim();
    for (int k = 0; k < 4; k++) begin
      src_n[k] = 0;
      src_start[k] = 0;
    end
    for (int c = 0; c < 32; c++) begin
      mready_sched[c] = 1'b1;
      rst_sched[c] = 1'b0;
    end
  endtask

  task automatic add_beat(input int k, input logic [31:0] d, input logic l);
    src_d[k][src_n[k]] = d;
    src_l[k][src_n[k]] = l;
    src_n[k]++;
  endtask

  task automatic idle_inputs();
    s2.tvalid = '0; s2.tdata = '0; s2.tlast = '0; s2.tid = '0;
    s4.tvalid = '0; s4.tdata = '0; s4.tlast = '0; s4.tid = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Plays the beat lists into the DUTs; sources advance only on their own handshake.
  task automatic run(input bit use4, input int ncyc);
    int          pos [4];
    logic [3:0]  fire;
    logic [3:0]  vv, ll, sv, sr;
    logic [31:0] dd [4];
    fire = '0;
    for (int k = 0; k < 4; k++) pos[k] = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) if (fire[k]) pos[k]++;
      rst = rst_sched[c];
      m2.tready = mready_sched[c];
      m4.tready = mready_sched[c];
      for (int k = 0; k < 4; k++) begin
        vv[k] = (c >= src_start[k]) && (pos[k] < src_n[k]);
        dd[k] = '0;
        ll[k] = 1'b0;
        if (vv[k]) begin
          dd[k] = src_d[k][pos[k]];
          ll[k] = src_l[k][pos[k]];
        end
      end
      s4.tvalid = vv; s4.tlast = ll; s4.tdata = {dd[3], dd[2], dd[1], dd[0]};
      s2.tvalid = vv[1:0]; s2.tlast = ll[1:0]; s2.tdata = {dd[1], dd[0]};
      @(negedge clk);
      if (use4) begin
        obs_mv[c] = m4.tvalid[0]; obs_md[c] = m4.tdata; obs_ml[c] = m4.tlast[0];
        obs_tid[c] = int'(m4.tid); obs_grant[c] = grant4; obs_busy[c] = busy4;
        sr = s4.tready; sv = s4.tvalid;
        obs_fire[c] = m4.tvalid[0] & m4.tready[0];
      end else begin
        obs_mv[c] = m2.tvalid[0]; obs_md[c] = m2.tdata; obs_ml[c] = m2.tlast[0];
        obs_tid[c] = int'(m2.tid); obs_grant[c] = {2'b00, grant2}; obs_busy[c] = busy2;
        sr = {2'b00, s2.tready}; sv = {2'b00, s2.tvalid};
        obs_fire[c] = m2.tvalid[0] & m2.tready[0];
      end
      obs_sready[c] = sr;
      fire = sv & sr;
      if (obs_fire[c])
        $display("beat cycle=%0d tid=%0d data=%h last=%b", c, obs_tid[c], obs_md[c], obs_ml[c]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s2.tvalid = 2'b11; s2.tdata = {32'h1111_2222, 32'h3333_4444}; s2.tlast = 2'b11; s2.tid = '0;
    s4.tvalid = 4'hF;  s4.tdata = {4{32'hDEAD_BEEF}}; s4.tlast = 4'hF; s4.tid = '0;
    m2.tready = 1'b1; m4.tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({grant2, busy2, m2.tvalid, m2.tlast, m2.tid, s2.tready} !== 8'h00 || m2.tdata !== 32'h0) begin
      bad++;
      $display("FAIL reset2 got grant=%b busy=%b v=%b l=%b id=%b rdy=%b d=%h want all 0",
               grant2, busy2, m2.tvalid, m2.tlast, m2.tid, s2.tready, m2.tdata);
    end
    total++;
    if ({grant4, busy4, m4.tvalid, m4.tlast, m4.tid, s4.tready} !== 14'h0 || m4.tdata !== 32'h0) begin
      bad++;
      $display("FAIL reset4 got grant=%b busy=%b v=%b l=%b id=%b rdy=%b d=%h want all 0",
               grant4, busy4, m4.tvalid, m4.tlast, m4.tid, s4.tready, m4.tdata);
    end
    #1 rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_source();
    clear_stim();
    for (int b = 1; b <= 6; b++) add_beat(0, 32'(b), b == 6);
    do_reset();
    run(1'b0, 9);
    total++;
    if (obs_busy[0] !== 1'b0 || obs_mv[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_arb got busy=%b valid=%b want 0 0", obs_busy[0], obs_mv[0]);
    end
    for (int c = 1; c <= 6; c++) begin
      total++;
      if (obs_fire[c] !== 1'b1 || obs_md[c] !== 32'(c) || obs_ml[c] !== (c == 6) || obs_tid[c] != 0
          || obs_grant[c] !== 4'b0001) begin
        bad++;
        $display("FAIL single_beat%0d got fire=%b data=%h last=%b tid=%0d grant=%b want 1 %h %b 0 0001",
                 c, obs_fire[c], obs_md[c], obs_ml[c], obs_tid[c], obs_grant[c], c, c == 6);
      end
    end
    total++;
    if (obs_busy[7] !== 1'b0 || obs_grant[7] !== 4'b0000) begin
      bad++;
      $display("FAIL single_done got busy=%b grant=%b want 0 0000", obs_busy[7], obs_grant[7]);
    end
  endtask

  task automatic test_contention();
    int          ef [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [31:0] ed [9] = '{0, 32'hA, 32'hB, 32'hC, 0, 32'h1A, 32'h1B, 32'h1C, 0};
    int          et [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    int          el [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    clear_stim();
    add_beat(0, 32'hA, 1'b0);  add_beat(0, 32'hB, 1'b0);  add_beat(0, 32'hC, 1'b1);
    add_beat(1, 32'h1A, 1'b0); add_beat(1, 32'h1B, 1'b0); add_beat(1, 32'h1C, 1'b1);
    do_reset();
    run(1'b0, 9);
    for (int c = 0; c < 9; c++) begin
      total++;
      if (obs_fire[c] !== ef[c][0] || obs_busy[c] !== ef[c][0]
          || (ef[c] == 1 && (obs_md[c] !== ed[c] || obs_tid[c] != et[c] || obs_ml[c] !== el[c][0]))) begin
        bad++;
        $display("FAIL contention_c%0d got fire=%b busy=%b data=%h tid=%0d last=%b want fire=%0d data=%h tid=%0d last=%0d",
                 c, obs_fire[c], obs_busy[c], obs_md[c], obs_tid[c], obs_ml[c], ef[c], ed[c], et[c], el[c]);
      end
    end
  endtask

  task automatic test_fairness();
    int          fc [8] = '{1, 2, 4, 5, 7, 8, 10, 11};
    logic [31:0] fd [8] = '{32'h01, 32'h02, 32'h11, 32'h12, 32'h03, 32'h04, 32'h13, 32'h14};
    int          ft [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    clear_stim();
    add_beat(0, 32'h01, 1'b0); add_beat(0, 32'h02, 1'b1);
    add_beat(0, 32'h03, 1'b0); add_beat(0, 32'h04, 1'b1);
    add_beat(1, 32'h11, 1'b0); add_beat(1, 32'h12, 1'b1);
    add_beat(1, 32'h13, 1'b0); add_beat(1, 32'h14, 1'b1);
    do_reset();
    run(1'b0, 13);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs_fire[fc[i]] !== 1'b1 || obs_md[fc[i]] !== fd[i] || obs_tid[fc[i]] != ft[i]) begin
        bad++;
        $display("FAIL fairness_beat%0d got fire=%b data=%h tid=%0d want 1 %h %0d",
                 i, obs_fire[fc[i]], obs_md[fc[i]], obs_tid[fc[i]], fd[i], ft[i]);
      end
    end
    total++;
    if (obs_busy[3] !== 1'b0 || obs_busy[6] !== 1'b0 || obs_busy[9] !== 1'b0) begin
      bad++;
      $display("FAIL fairness_gaps got busy c3=%b c6=%b c9=%b want 0 0 0", obs_busy[3], obs_busy[6], obs_busy[9]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pd [3] = '{32'h22, 32'h23, 32'h24};
    clear_stim();
    for (int b = 1; b <= 4; b++) add_beat(1, 32'h20 + 32'(b), b == 4);
    add_beat(0, 32'h05, 1'b1);
    src_start[0] = 2;
    for (int c = 2; c < 12; c++) mready_sched[c] = 1'b0;
    do_reset();
    run(1'b0, 17);
    total++;
    if (obs_fire[1] !== 1'b1 || obs_md[1] !== 32'h21 || obs_tid[1] != 1 || obs_grant[1] !== 4'b0010) begin
      bad++;
      $display("FAIL bp_first got fire=%b data=%h tid=%0d grant=%b want 1 21 1 0010",
               obs_fire[1], obs_md[1], obs_tid[1], obs_grant[1]);
    end
    for (int c = 2; c < 12; c++) begin
      total++;
      if (obs_fire[c] !== 1'b0 || obs_md[c] !== 32'h22 || obs_mv[c] !== 1'b1 || obs_grant[c] !== 4'b0010
          || obs_sready[c] !== 4'b0000) begin
        bad++;
        $display("FAIL bp_stall_c%0d got fire=%b valid=%b data=%h grant=%b sready=%b want 0 1 22 0010 0000",
                 c, obs_fire[c], obs_mv[c], obs_md[c], obs_grant[c], obs_sready[c]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_fire[12+i] !== 1'b1 || obs_md[12+i] !== pd[i] || obs_ml[12+i] !== (i == 2)
          || obs_sready[12+i] !== 4'b0010) begin
        bad++;
        $display("FAIL bp_resume%0d got fire=%b data=%h last=%b sready=%b want 1 %h %b 0010",
                 i, obs_fire[12+i], obs_md[12+i], obs_ml[12+i], obs_sready[12+i], pd[i], i == 2);
      end
    end
    total++;
    if (obs_busy[15] !== 1'b0 || obs_fire[16] !== 1'b1 || obs_md[16] !== 32'h05 || obs_tid[16] != 0) begin
      bad++;
      $display("FAIL bp_port0 got busy15=%b fire16=%b data=%h tid=%0d want 0 1 05 0",
               obs_busy[15], obs_fire[16], obs_md[16], obs_tid[16]);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_stim();
    for (int b = 1; b <= 6; b++) add_beat(1, 32'h30 + 32'(b), b == 6);
    add_beat(0, 32'h07, 1'b1);
    src_start[0] = 3;
    rst_sched[3] = 1'b1;
    mready_sched[3] = 1'b0;
    do_reset();
    run(1'b0, 7);
    total++;
    if (obs_fire[2] !== 1'b1 || obs_md[2] !== 32'h32 || obs_busy[3] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got fire2=%b data=%h busy3=%b want 1 32 1", obs_fire[2], obs_md[2], obs_busy[3]);
    end
    total++;
    if (obs_busy[4] !== 1'b0 || obs_grant[4] !== 4'b0000 || obs_mv[4] !== 1'b0 || obs_md[4] !== 32'h0
        || obs_ml[4] !== 1'b0 || obs_tid[4] != 0 || obs_sready[4] !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_zero got busy=%b grant=%b v=%b d=%h l=%b tid=%0d sready=%b want all 0",
               obs_busy[4], obs_grant[4], obs_mv[4], obs_md[4], obs_ml[4], obs_tid[4], obs_sready[4]);
    end
    total++;
    if (obs_grant[5] !== 4'b0001 || obs_fire[5] !== 1'b1 || obs_md[5] !== 32'h07 || obs_tid[5] != 0) begin
      bad++;
      $display("FAIL rstmid_port0 got grant=%b fire=%b data=%h tid=%0d want 0001 1 07 0",
               obs_grant[5], obs_fire[5], obs_md[5], obs_tid[5]);
    end
  endtask

  task automatic test_wrap4();
    int          ef [8] = '{0, 1, 1, 0, 1, 1, 0, 1};
    logic [31:0] ed [8] = '{0, 32'h41, 32'h42, 0, 32'h61, 32'h62, 0, 32'h43};
    int          et [8] = '{0, 1, 1, 0, 3, 3, 0, 1};
    logic [3:0]  eg [8] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0010};
    clear_stim();
    add_beat(1, 32'h41, 1'b0); add_beat(1, 32'h42, 1'b1); add_beat(1, 32'h43, 1'b1);
    add_beat(3, 32'h61, 1'b0); add_beat(3, 32'h62, 1'b1);
    do_reset();
    run(1'b1, 8);
    for (int c = 0; c < 8; c++) begin
      total++;
      if (obs_fire[c] !== ef[c][0] || obs_grant[c] !== eg[c]
          || (ef[c] == 1 && (obs_md[c] !== ed[c] || obs_tid[c] != et[c]))) begin
        bad++;
        $display("FAIL wrap4_c%0d got fire=%b grant=%b data=%h tid=%0d want fire=%0d grant=%b data=%h tid=%0d",
                 c, obs_fire[c], obs_grant[c], obs_md[c], obs_tid[c], ef[c], eg[c], ed[c], et[c]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    m2.tready = 1'b0;
    m4.tready = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid_packet();
    test_wrap4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
